rename_map_table: RTL and testbench
===================================

Name: rename_map_table

Overview:
- Register-rename map table for the R10K-style out-of-order core.
- Holds, for each of 32 architectural registers, the current physical register (6-bit tag) and a ready bit.
- Sits in the dispatch stage:
  - supplies source tags and readiness to the reservation station;
  - supplies the old destination tag to the ROB;
  - is updated by dispatch, by CDB broadcasts, and by a branch-recovery restore from the architectural map.

Parameters:
NUM_AREG, 32, number of architectural registers (index width 5)
NUM_PREG, 64, number of physical registers (tag width 6)
ZERO_AREG, 31, hardwired-zero architectural register, never renamed

Ports:
clk  input  1  clock, rising edge
rst  input  1  synchronous, active-high reset
opa_areg_idx_i  input  5  source A architectural index
opb_areg_idx_i  input  5  source B architectural index
dest_areg_idx_i  input  5  destination architectural index
new_free_preg_i  input  6  tag from free list for the destination
dispatch_en_i  input  1  commit the rename of dest_areg_idx_i this cycle
cdb_set_RDYit_preg_i  input  6  tag completing on CDB
cdb_set_RDYit_en_i  input  1  CDB broadcast valid
preg_restore_dump_i  input  32x6  full architectural map for recovery (entry i = tag of areg i)
preg_restore_dump_en_i  input  1  restore the whole table
opa_preg_o  output  6  current tag of source A
opb_preg_o  output  6  current tag of source B
opa_preg_RDYit_o  output  1  source A value available
opb_preg_RDYit_o  output  1  source B value available
dest_old_preg_o  output  6  tag being replaced for the destination (to ROB, freed at retire)

Behaviour:
- State: map[0..31] (6 bits each), rdy[0..31] (1 bit each).
- Reset (clk edge with rst=1): map[i]=i, rdy[i]=1 for all i. Reset has highest priority.
- Reads are combinational from the current (pre-edge) state:
  - opa_preg_o = map[opa_areg_idx_i]; opb_preg_o = map[opb_areg_idx_i];
  - dest_old_preg_o = map[dest_areg_idx_i].
  - The same-cycle dispatch write is not visible, so a source equal to its own destination reads the old mapping.
- Ready outputs:
  - opX_preg_RDYit_o = rdy[opX] OR (cdb_set_RDYit_en_i AND cdb_set_RDYit_preg_i == map[opX]).
  - This is a CDB bypass, so no wakeup is lost.
  - Outputs are valid after reset even while dispatch_en_i=0.
- Sequential update priority per edge: rst > restore > (dispatch, CDB).
  - Restore: map[i] <= preg_restore_dump_i[i] for all i; rdy[i] <= 1 for all i; dispatch and CDB ignored that cycle.
  - CDB: for every i with map[i] == cdb_set_RDYit_preg_i, rdy[i] <= 1 (associative match on current tags).
  - Dispatch: if dispatch_en_i and dest_areg_idx_i != ZERO_AREG, map[dest] <= new_free_preg_i and rdy[dest] <= 0. This overrides a CDB set on the same entry in the same cycle.
  - Dispatch to ZERO_AREG: no state change; dest_old_preg_o still reports map[31]; map[31] stays 31 and rdy[31] stays 1 permanently.
- A CDB tag matching no entry causes no change.
- Without restore, the map is a permutation-free set of distinct tags; the block does not check this.

Decomposition:
- Shared package: AREG_W=5, PREG_W=6, NUM_AREG, NUM_PREG, ZERO_AREG, and typedefs areg_idx_t and preg_tag_t.
- The port-type mismatch with the 32x6 restore bus is resolved by a packed [31:0][5:0] array of preg_tag_t.
- No sub-module; one flat module with a generate loop over entries (per-entry CDB compare and write enable).

Test Plan:
- Reset then read: opa=3, opb=7, dest=5 -> opa_preg_o=3, opb_preg_o=7, both RDY=1, dest_old=5.
- Dispatch dest=5, new=40. Next cycle opa=5 -> opa_preg_o=40, RDY=0, dest_old (dest=5)=40. In the dispatch cycle, dest_old=5 and opa=5 reads 5.
- CDB tag 40 with opa=5 -> opa RDY=1 combinationally in the same cycle, and rdy[5]=1 persists after CDB deasserts.
- Same cycle: dispatch dest=5 new=41 and CDB tag 40 -> next cycle map[5]=41, rdy=0. Then CDB 41 -> rdy=1.
- Dispatch dest=31, new=50 -> map[31] stays 31, RDY=1.
- After several dispatches, restore with dump[i]=i+32 together with dispatch_en=1 -> next cycle map[i]=i+32 and all RDY=1 (dispatch ignored). Then assert rst -> identity map restored.

Source files
------------

// File: rtl/rename_map_table_pkg.sv
// Shared widths, sizes and tag/index types for the register-rename map table.
// The restore bus type is a packed array so a whole architectural map moves as one port.
package rename_map_table_pkg;

    localparam int AREG_W    = 5;
    localparam int PREG_W    = 6;
    localparam int NUM_AREG  = 32;
    localparam int NUM_PREG  = 64;
    localparam int ZERO_AREG = 31;

    typedef logic [AREG_W-1:0] areg_idx_t;
    typedef logic [PREG_W-1:0] preg_tag_t;

    // Entry i holds the physical tag of architectural register i.
    typedef preg_tag_t [NUM_AREG-1:0] preg_map_t;

endpackage

// File: rtl/rename_map_table_if.sv
// Dispatch/CDB/recovery bundle of the rename map table.
// The master drives lookups and updates; the slave (the table) returns tags and readiness.
interface rename_map_table_if;
    import rename_map_table_pkg::*;

    areg_idx_t opa_areg_idx_i;
    areg_idx_t opb_areg_idx_i;
    areg_idx_t dest_areg_idx_i;
    preg_tag_t new_free_preg_i;
    logic      dispatch_en_i;
    preg_tag_t cdb_set_RDYit_preg_i;
    logic      cdb_set_RDYit_en_i;
    preg_map_t preg_restore_dump_i;
    logic      preg_restore_dump_en_i;

    preg_tag_t opa_preg_o;
    preg_tag_t opb_preg_o;
    logic      opa_preg_RDYit_o;
    logic      opb_preg_RDYit_o;
    preg_tag_t dest_old_preg_o;

    modport master (
        output opa_areg_idx_i, opb_areg_idx_i, dest_areg_idx_i, new_free_preg_i,
               dispatch_en_i, cdb_set_RDYit_preg_i, cdb_set_RDYit_en_i,
               preg_restore_dump_i, preg_restore_dump_en_i,
        input  opa_preg_o, opb_preg_o, opa_preg_RDYit_o, opb_preg_RDYit_o, dest_old_preg_o
    );

    modport slave (
        input  opa_areg_idx_i, opb_areg_idx_i, dest_areg_idx_i, new_free_preg_i,
               dispatch_en_i, cdb_set_RDYit_preg_i, cdb_set_RDYit_en_i,
               preg_restore_dump_i, preg_restore_dump_en_i,
        output opa_preg_o, opb_preg_o, opa_preg_RDYit_o, opb_preg_RDYit_o, dest_old_preg_o
    );

endinterface

// File: rtl/rename_map_table.sv
// Register-rename map table: per-architectural-register physical tag plus ready bit,
// read combinationally at dispatch and updated by dispatch, CDB wakeup and branch restore.
module rename_map_table
    import rename_map_table_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    rename_map_table_if.slave mt
);

    preg_map_t             map_cur;
    logic [NUM_AREG-1:0]   rdy_cur;

    for (genvar i = 0; i < NUM_AREG; i++) begin : g_entry
        localparam areg_idx_t IDX = areg_idx_t'(i);

        preg_tag_t map_q, map_d;
        logic      rdy_q, rdy_d;
        logic      cdb_hit;
        logic      disp_wr;

        assign cdb_hit = mt.cdb_set_RDYit_en_i && (map_q == mt.cdb_set_RDYit_preg_i);

        // The zero register is never renamed, so it has no dispatch write port.
        if (i == ZERO_AREG) begin : g_zero
            assign disp_wr = 1'b0;
        end else begin : g_norm
            assign disp_wr = mt.dispatch_en_i && (mt.dest_areg_idx_i == IDX);
        end

        // Dispatch wins over a CDB set on the same entry: the new tag is not yet produced.
        always_comb begin
            map_d = map_q;
            rdy_d = rdy_q;
            if (mt.preg_restore_dump_en_i) begin
                map_d = mt.preg_restore_dump_i[i];
                rdy_d = 1'b1;
            end else if (disp_wr) begin
                map_d = mt.new_free_preg_i;
                rdy_d = 1'b0;
            end else if (cdb_hit) begin
                rdy_d = 1'b1;
            end
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                map_q <= preg_tag_t'(i);
                rdy_q <= 1'b1;
            end else begin
                map_q <= map_d;
                rdy_q <= rdy_d;
            end
        end

        assign map_cur[i] = map_q;
        assign rdy_cur[i] = rdy_q;
    end

    // Reads see pre-edge state; the CDB bypass keeps a same-cycle wakeup from being lost.
    assign mt.opa_preg_o       = map_cur[mt.opa_areg_idx_i];
    assign mt.opb_preg_o       = map_cur[mt.opb_areg_idx_i];
    assign mt.dest_old_preg_o  = map_cur[mt.dest_areg_idx_i];

    assign mt.opa_preg_RDYit_o = rdy_cur[mt.opa_areg_idx_i] ||
                                 (mt.cdb_set_RDYit_en_i &&
                                  (mt.cdb_set_RDYit_preg_i == map_cur[mt.opa_areg_idx_i]));
    assign mt.opb_preg_RDYit_o = rdy_cur[mt.opb_areg_idx_i] ||
                                 (mt.cdb_set_RDYit_en_i &&
                                  (mt.cdb_set_RDYit_preg_i == map_cur[mt.opb_areg_idx_i]));

endmodule

// File: tb/tb_rename_map_table.sv
// Directed bench for rename_map_table: reset map, rename, CDB wakeup/bypass,
// dispatch-over-CDB priority, zero register, restore and re-reset.
module tb_rename_map_table;
    import rename_map_table_pkg::*;

    logic clk;
    logic rst;
    int   n_tests;
    int   n_fail;

    rename_map_table_if mt_if ();

    rename_map_table dut (
        .clk (clk),
        .rst (rst),
        .mt  (mt_if.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $display("FAIL %s: observed %0d expected %0d", tag, obs, exp);
            $error("check %s mismatch", tag);
        end
    endtask

    // Advance past a rising edge; inputs are then changed 1ns after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        preg_map_t dump;
        n_tests = 0;
        n_fail  = 0;
        rst = 1'b1;
        mt_if.opa_areg_idx_i         = '0;
        mt_if.opb_areg_idx_i         = '0;
        mt_if.dest_areg_idx_i        = '0;
        mt_if.new_free_preg_i        = '0;
        mt_if.dispatch_en_i          = 1'b0;
        mt_if.cdb_set_RDYit_preg_i   = '0;
        mt_if.cdb_set_RDYit_en_i     = 1'b0;
        mt_if.preg_restore_dump_i    = '0;
        mt_if.preg_restore_dump_en_i = 1'b0;
        tick();
        tick();
        rst = 1'b0;

        // Reset state
        mt_if.opa_areg_idx_i  = 5'd3;
        mt_if.opb_areg_idx_i  = 5'd7;
        mt_if.dest_areg_idx_i = 5'd5;
        #1;
        chk("rst_opa",      8'(mt_if.opa_preg_o), 8'd3);
        chk("rst_opb",      8'(mt_if.opb_preg_o), 8'd7);
        chk("rst_opa_rdy",  8'(mt_if.opa_preg_RDYit_o), 8'd1);
        chk("rst_opb_rdy",  8'(mt_if.opb_preg_RDYit_o), 8'd1);
        chk("rst_dest_old", 8'(mt_if.dest_old_preg_o), 8'd5);

        // Dispatch dest=5 -> 40; same-cycle reads see the old mapping
        mt_if.opa_areg_idx_i  = 5'd5;
        mt_if.new_free_preg_i = 6'd40;
        mt_if.dispatch_en_i   = 1'b1;
        #1;
        chk("disp_cyc_dest_old", 8'(mt_if.dest_old_preg_o), 8'd5);
        chk("disp_cyc_opa",      8'(mt_if.opa_preg_o), 8'd5);
        chk("disp_cyc_opa_rdy",  8'(mt_if.opa_preg_RDYit_o), 8'd1);
        tick();
        mt_if.dispatch_en_i = 1'b0;
        #1;
        chk("disp_opa",      8'(mt_if.opa_preg_o), 8'd40);
        chk("disp_opa_rdy",  8'(mt_if.opa_preg_RDYit_o), 8'd0);
        chk("disp_dest_old", 8'(mt_if.dest_old_preg_o), 8'd40);

        // CDB 40: combinational bypass, then persistent ready
        mt_if.cdb_set_RDYit_preg_i = 6'd40;
        mt_if.cdb_set_RDYit_en_i   = 1'b1;
        #1;
        chk("cdb_bypass_opa_rdy", 8'(mt_if.opa_preg_RDYit_o), 8'd1);
        tick();
        mt_if.cdb_set_RDYit_en_i = 1'b0;
        #1;
        chk("cdb_held_opa_rdy", 8'(mt_if.opa_preg_RDYit_o), 8'd1);
        chk("cdb_held_opa",     8'(mt_if.opa_preg_o), 8'd40);

        // Dispatch dest=5 -> 41 with CDB 40 in the same cycle: dispatch wins
        mt_if.new_free_preg_i      = 6'd41;
        mt_if.dispatch_en_i        = 1'b1;
        mt_if.cdb_set_RDYit_preg_i = 6'd40;
        mt_if.cdb_set_RDYit_en_i   = 1'b1;
        tick();
        mt_if.dispatch_en_i      = 1'b0;
        mt_if.cdb_set_RDYit_en_i = 1'b0;
        #1;
        chk("prio_opa",     8'(mt_if.opa_preg_o), 8'd41);
        chk("prio_opa_rdy", 8'(mt_if.opa_preg_RDYit_o), 8'd0);
        mt_if.cdb_set_RDYit_preg_i = 6'd41;
        mt_if.cdb_set_RDYit_en_i   = 1'b1;
        tick();
        mt_if.cdb_set_RDYit_en_i = 1'b0;
        #1;
        chk("cdb41_opa_rdy", 8'(mt_if.opa_preg_RDYit_o), 8'd1);

        // Dispatch dest=7 -> 42, then an unmatched CDB tag leaves it not ready
        mt_if.dest_areg_idx_i = 5'd7;
        mt_if.new_free_preg_i = 6'd42;
        mt_if.dispatch_en_i   = 1'b1;
        tick();
        mt_if.dispatch_en_i        = 1'b0;
        mt_if.cdb_set_RDYit_preg_i = 6'd63;
        mt_if.cdb_set_RDYit_en_i   = 1'b1;
        #1;
        chk("nomatch_byp_opb_rdy", 8'(mt_if.opb_preg_RDYit_o), 8'd0);
        tick();
        mt_if.cdb_set_RDYit_en_i = 1'b0;
        #1;
        chk("nomatch_opb",     8'(mt_if.opb_preg_o), 8'd42);
        chk("nomatch_opb_rdy", 8'(mt_if.opb_preg_RDYit_o), 8'd0);
        chk("nomatch_opa_rdy", 8'(mt_if.opa_preg_RDYit_o), 8'd1);

        // Dispatch to the zero register changes nothing
        mt_if.dest_areg_idx_i = 5'd31;
        mt_if.opa_areg_idx_i  = 5'd31;
        mt_if.new_free_preg_i = 6'd50;
        mt_if.dispatch_en_i   = 1'b1;
        #1;
        chk("zero_cyc_dest_old", 8'(mt_if.dest_old_preg_o), 8'd31);
        tick();
        mt_if.dispatch_en_i = 1'b0;
        #1;
        chk("zero_opa",      8'(mt_if.opa_preg_o), 8'd31);
        chk("zero_opa_rdy",  8'(mt_if.opa_preg_RDYit_o), 8'd1);
        chk("zero_dest_old", 8'(mt_if.dest_old_preg_o), 8'd31);

        // Dispatch dest=3 -> 45 so restore has more to overwrite
        mt_if.dest_areg_idx_i = 5'd3;
        mt_if.new_free_preg_i = 6'd45;
        mt_if.dispatch_en_i   = 1'b1;
        tick();
        mt_if.dispatch_en_i = 1'b0;
        mt_if.opa_areg_idx_i = 5'd3;
        #1;
        chk("pre_rest_opa", 8'(mt_if.opa_preg_o), 8'd45);

        // Restore dump[i]=i+32 alongside a dispatch that must be ignored
        for (int i = 0; i < NUM_AREG; i++) dump[i] = preg_tag_t'(i + 32);
        mt_if.preg_restore_dump_i    = dump;
        mt_if.preg_restore_dump_en_i = 1'b1;
        mt_if.dispatch_en_i          = 1'b1;
        mt_if.dest_areg_idx_i        = 5'd3;
        mt_if.new_free_preg_i        = 6'd55;
        tick();
        mt_if.preg_restore_dump_en_i = 1'b0;
        mt_if.dispatch_en_i          = 1'b0;
        mt_if.opb_areg_idx_i         = 5'd7;
        #1;
        chk("rest_opa",      8'(mt_if.opa_preg_o), 8'd35);
        chk("rest_opa_rdy",  8'(mt_if.opa_preg_RDYit_o), 8'd1);
        chk("rest_opb",      8'(mt_if.opb_preg_o), 8'd39);
        chk("rest_opb_rdy",  8'(mt_if.opb_preg_RDYit_o), 8'd1);
        chk("rest_dest_old", 8'(mt_if.dest_old_preg_o), 8'd35);
        mt_if.opa_areg_idx_i = 5'd5;
        #1;
        chk("rest_opa5",     8'(mt_if.opa_preg_o), 8'd37);
        chk("rest_opa5_rdy", 8'(mt_if.opa_preg_RDYit_o), 8'd1);

        // Re-reset restores the identity map
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        chk("rerst_opa",      8'(mt_if.opa_preg_o), 8'd5);
        chk("rerst_opb",      8'(mt_if.opb_preg_o), 8'd7);
        chk("rerst_opb_rdy",  8'(mt_if.opb_preg_RDYit_o), 8'd1);
        chk("rerst_dest_old", 8'(mt_if.dest_old_preg_o), 8'd3);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
